krn_sop_pos: RTL and testbench

- Registered evaluator of one fixed 4-input Boolean function F(a,b,c,d), implemented three ways in parallel:
  - Karnaugh-minimised form (krn)
  - canonical sum-of-products (sop)
  - canonical product-of-sums (pos)
- Serves as the gate-level logic-minimisation reference block; the three outputs must always agree.
- Input index convention: a is the MSB, m = {a,b,c,d}.
- F = Σm(0,1,2,5,8,9,10) = ΠM(3,4,6,7,11,12,13,14,15).

---
 rtl/krn_sop_pos_pkg.sv | 9 +
 rtl/krn_sop_pos_eval.sv | 26 ++
 rtl/krn_sop_pos.sv | 76 +++++++
 tb/tb_krn_sop_pos.sv | 117 +++++++++++
 4 files changed

// File: rtl/krn_sop_pos_pkg.sv
// krn_sop_pos_pkg: truth-table constant, term counts and index helper for F = Sm(0,1,2,5,8,9,10)
package krn_sop_pos_pkg;
  localparam logic [15:0] F_TRUTH = 16'h0727;
  localparam int MINTERMS = 7;
  localparam int MAXTERMS = 9;
  function automatic logic [3:0] idx4(input logic a, input logic b, input logic c, input logic d);
    return {a, b, c, d};
  endfunction
endpackage

// File: rtl/krn_sop_pos_eval.sv
// krn_sop_pos_eval: independent minimal/SOP/POS evaluations of F, plus table lookup under KSP_ORACLE_CHECK_EN
module krn_sop_pos_eval
  import krn_sop_pos_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic c,
  input  logic d,
`ifdef KSP_ORACLE_CHECK_EN
  output logic f_tab_c,
`endif
  output logic f_krn_c,
  output logic f_sop_c,
  output logic f_pos_c
);
  assign f_krn_c = (~b & ~c) | (~b & ~d) | (~a & ~c & d);
  assign f_sop_c = (~a & ~b & ~c & ~d) | (~a & ~b & ~c & d) | (~a & ~b & c & ~d) |
                   (~a & b & ~c & d) | (a & ~b & ~c & ~d) | (a & ~b & ~c & d) |
                   (a & ~b & c & ~d);
  assign f_pos_c = (a | b | ~c | ~d) & (a | ~b | c | d) & (a | ~b | ~c | d) &
                   (a | ~b | ~c | ~d) & (~a | b | ~c | ~d) & (~a | ~b | c | d) &
                   (~a | ~b | c | ~d) & (~a | ~b | ~c | d) & (~a | ~b | ~c | ~d);
`ifdef KSP_ORACLE_CHECK_EN
  assign f_tab_c = F_TRUTH[idx4(a, b, c, d)];
`endif
endmodule

// File: rtl/krn_sop_pos.sv
// krn_sop_pos: registered three-way evaluator of F with mismatch flag and saturating error count; KSP_ORACLE_CHECK_EN adds a table oracle
module krn_sop_pos
  import krn_sop_pos_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             a,
  input  logic             b,
  input  logic             c,
  input  logic             d,
  output logic             out_valid,
  output logic             f_krn,
  output logic             f_sop,
  output logic             f_pos,
  output logic             mismatch,
  output logic [CNT_W-1:0] err_cnt
);
  logic f_krn_c, f_sop_c, f_pos_c, mm_c;
  logic out_valid_d, f_krn_d, f_sop_d, f_pos_d, mismatch_d;
  logic out_valid_q, f_krn_q, f_sop_q, f_pos_q, mismatch_q;
  logic [CNT_W-1:0] err_cnt_d, err_cnt_q;
`ifdef KSP_ORACLE_CHECK_EN
  logic f_tab_c;
`endif
  krn_sop_pos_eval u_eval (
    .a(a),
    .b(b),
    .c(c),
    .d(d),
`ifdef KSP_ORACLE_CHECK_EN
    .f_tab_c(f_tab_c),
`endif
    .f_krn_c(f_krn_c),
    .f_sop_c(f_sop_c),
    .f_pos_c(f_pos_c)
  );
`ifdef KSP_ORACLE_CHECK_EN
  assign mm_c = !((f_krn_c == f_sop_c) && (f_sop_c == f_pos_c) && (f_pos_c == f_tab_c));
`else
  assign mm_c = !((f_krn_c == f_sop_c) && (f_sop_c == f_pos_c));
`endif
  always_comb begin
    out_valid_d = in_valid;
    f_krn_d = in_valid ? f_krn_c : f_krn_q;
    f_sop_d = in_valid ? f_sop_c : f_sop_q;
    f_pos_d = in_valid ? f_pos_c : f_pos_q;
    mismatch_d = in_valid & mm_c;
    err_cnt_d = (mismatch_d && err_cnt_q != '1) ? err_cnt_q + CNT_W'(1) : err_cnt_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      f_krn_q <= 1'b0;
      f_sop_q <= 1'b0;
      f_pos_q <= 1'b0;
      mismatch_q <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      f_krn_q <= f_krn_d;
      f_sop_q <= f_sop_d;
      f_pos_q <= f_pos_d;
      mismatch_q <= mismatch_d;
      err_cnt_q <= err_cnt_d;
    end
  end
  assign out_valid = out_valid_q;
  assign f_krn = f_krn_q;
  assign f_sop = f_sop_q;
  assign f_pos = f_pos_q;
  assign mismatch = mismatch_q;
  assign err_cnt = err_cnt_q;
endmodule

// File: tb/tb_krn_sop_pos.sv
// tb_krn_sop_pos: directed self-checking bench for krn_sop_pos, including forced faults and counter saturation
module tb_krn_sop_pos;
  logic clk = 1'b0;
  logic rst, in_valid, a, b, c, d;
  logic out_valid, f_krn, f_sop, f_pos, mismatch;
  logic [7:0] err_cnt;
  logic o2_valid, o2_krn, o2_sop, o2_pos, o2_mm;
  logic [1:0] o2_cnt;
  int n_chk = 0;
  int n_fail = 0;
  logic exp_f [16] = '{1, 1, 1, 0, 0, 1, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0};
  logic [3:0] spot_v [4] = '{4'b0101, 4'b0111, 4'b1010, 4'b1101};
  logic spot_e [4] = '{1, 0, 1, 0};
  always #5 clk = ~clk;
  krn_sop_pos dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b), .c(c), .d(d),
    .out_valid(out_valid), .f_krn(f_krn), .f_sop(f_sop), .f_pos(f_pos),
    .mismatch(mismatch), .err_cnt(err_cnt)
  );
  krn_sop_pos #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b), .c(c), .d(d),
    .out_valid(o2_valid), .f_krn(o2_krn), .f_sop(o2_sop), .f_pos(o2_pos),
    .mismatch(o2_mm), .err_cnt(o2_cnt)
  );
  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic v, input logic [3:0] m);
    in_valid = v;
    {a, b, c, d} = m;
  endtask
  task automatic chk_f(input string tag, input logic e);
    chk({tag, ".krn"}, {7'd0, f_krn}, {7'd0, e});
    chk({tag, ".sop"}, {7'd0, f_sop}, {7'd0, e});
    chk({tag, ".pos"}, {7'd0, f_pos}, {7'd0, e});
  endtask
  initial begin
    rst = 1'b1;
    drive(1'b1, 4'b0000);
    step();
    step();
    chk("rst.out_valid", {7'd0, out_valid}, 8'd0);
    chk_f("rst", 1'b0);
    chk("rst.mismatch", {7'd0, mismatch}, 8'd0);
    chk("rst.err_cnt", err_cnt, 8'd0);
    rst = 1'b0;
    for (int m = 0; m < 16; m++) begin
      drive(1'b1, 4'(m));
      step();
      chk($sformatf("sweep%0d.valid", m), {7'd0, out_valid}, 8'd1);
      chk_f($sformatf("sweep%0d", m), exp_f[m]);
      chk($sformatf("sweep%0d.mm", m), {7'd0, mismatch}, 8'd0);
    end
    chk("sweep.err_cnt", err_cnt, 8'd0);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, spot_v[i]);
      step();
      chk_f($sformatf("spot%b", spot_v[i]), spot_e[i]);
    end
    drive(1'b1, 4'b0101);
    step();
    chk_f("bub.load", 1'b1);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 4'b1111);
      if (i == 2) a = 1'bx;
      step();
      chk($sformatf("bub%0d.valid", i), {7'd0, out_valid}, 8'd0);
      chk($sformatf("bub%0d.mm", i), {7'd0, mismatch}, 8'd0);
      chk_f($sformatf("bub%0d", i), 1'b1);
    end
    drive(1'b1, 4'b0011);
    force dut.f_sop_c = 1'b1;
    force dut2.f_sop_c = 1'b1;
    step();
    chk("flt.mm", {7'd0, mismatch}, 8'd1);
    chk("flt.err_cnt", err_cnt, 8'd1);
    chk("flt.krn", {7'd0, f_krn}, 8'd0);
    chk("flt.sop", {7'd0, f_sop}, 8'd1);
    step();
    step();
    chk("flt3.err_cnt2", {6'd0, o2_cnt}, 8'd3);
    step();
    step();
    chk("flt5.err_cnt", err_cnt, 8'd5);
    chk("flt5.err_cnt2", {6'd0, o2_cnt}, 8'd3);
    chk("flt5.mm2", {7'd0, o2_mm}, 8'd1);
    release dut.f_sop_c;
    release dut2.f_sop_c;
    step();
    chk("rel.mm", {7'd0, mismatch}, 8'd0);
    chk("rel.err_cnt", err_cnt, 8'd5);
    chk_f("rel", 1'b0);
    drive(1'b1, 4'b0000);
    step();
    chk_f("pre_rst", 1'b1);
    rst = 1'b1;
    step();
    chk("mrst.valid", {7'd0, out_valid}, 8'd0);
    chk_f("mrst", 1'b0);
    chk("mrst.err_cnt", err_cnt, 8'd0);
    chk("mrst.err_cnt2", {6'd0, o2_cnt}, 8'd0);
    rst = 1'b0;
    step();
    chk("post.valid", {7'd0, out_valid}, 8'd1);
    chk_f("post", 1'b1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
